// File: rtl/axis_ramp_checker.sv
// rtl/axis_ramp_checker.sv - AXI-Stream ramp pattern checker with length and data error reporting.
// Optional AXIS_RAMP_CHECKER_THROTTLE_EN drives tready from a 16-bit LFSR.
module axis_ramp_checker #(
  parameter int DWIDTH = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DWIDTH-1:0] ramp_start,
  input  logic [DWIDTH-1:0] ramp_inc,
  input  logic [LEN_W-1:0]  exp_len,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [31:0]       pkt_count,
  output logic [31:0]       err_count,
  output logic [1:0]        err_code,
  output logic              error,
  output logic              pkt_done,
  output logic              pkt_ok
);

  typedef enum logic [1:0] {IDLE, IN_PKT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] acc_q, acc_d, inc_q, inc_d;
  logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d;
  logic [1:0]        code_q, code_d;
  logic              done_q, done_d, ok_q, ok_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              error_q, error_d;
  logic              tready_q;

  logic              beat;
  logic [DWIDTH-1:0] cur_exp, cur_inc;
  logic [LEN_W-1:0]  cur_len, cur_k;
  logic              data_err, short_err, long_err;
  logic [1:0]        beat_code, fin_code;
  logic              fin;

  // The first beat of a packet checks against the live inputs; later beats use the latched copies.
  always_comb begin
    beat      = s_axis_tvalid & tready_q;
    cur_exp   = (state_q == IDLE) ? ramp_start : acc_q;
    cur_inc   = (state_q == IDLE) ? ramp_inc   : inc_q;
    cur_len   = (state_q == IDLE) ? exp_len    : len_q;
    cur_k     = (state_q == IDLE) ? '0         : beat_q;
    data_err  = (s_axis_tdata != cur_exp);
    short_err = (cur_len != '0) && s_axis_tlast  && (cur_k <  cur_len - LEN_W'(1));
    long_err  = (cur_len != '0) && !s_axis_tlast && (cur_k == cur_len - LEN_W'(1));
    if (data_err)       beat_code = 2'd1;
    else if (short_err) beat_code = 2'd2;
    else if (long_err)  beat_code = 2'd3;
    else                beat_code = 2'd0;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    inc_d    = inc_q;
    len_d    = len_q;
    beat_d   = beat_q;
    code_d   = code_q;
    fin      = 1'b0;
    fin_code = 2'd0;
    if (beat) begin
      case (state_q)
        IDLE, IN_PKT: begin
          inc_d  = cur_inc;
          len_d  = cur_len;
          acc_d  = cur_exp + cur_inc;
          beat_d = cur_k + LEN_W'(1);
          if (s_axis_tlast) begin
            fin      = 1'b1;
            fin_code = beat_code;
            state_d  = IDLE;
          end else if (beat_code != 2'd0) begin
            code_d  = beat_code;
            state_d = DRAIN;
          end else begin
            state_d = IN_PKT;
          end
        end
        DRAIN: begin
          if (s_axis_tlast) begin
            fin      = 1'b1;
            fin_code = code_q;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    done_d     = fin;
    ok_d       = fin && (fin_code == 2'd0);
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    error_d    = error_q;
    if (clear) begin
      pkt_cnt_d  = '0;
      err_cnt_d  = '0;
      err_code_d = 2'd0;
      error_d    = 1'b0;
    end else if (fin) begin
      if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (fin_code != 2'd0) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
        err_code_d = fin_code;
        error_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      inc_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      code_q     <= 2'd0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_code_q <= 2'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      code_q     <= code_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
      error_q    <= error_d;
    end
  end

`ifdef AXIS_RAMP_CHECKER_THROTTLE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q   <= 16'hACE1;
      tready_q <= 1'b0;
    end else begin
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      tready_q <= |lfsr_q[1:0];
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tready_q <= 1'b0;
    else       tready_q <= 1'b1;
  end
`endif

  assign s_axis_tready = tready_q;
  assign pkt_count     = pkt_cnt_q;
  assign err_count     = err_cnt_q;
  assign err_code      = err_code_q;
  assign error         = error_q;
  assign pkt_done      = done_q;
  assign pkt_ok        = ok_q;

endmodule

// File: doc/axis_ramp_checker.md
AXIS_RAMP_CHECKER -- requirements
Module: axis_ramp_checker

Interface
REQ-001 Parameter DWIDTH, default 64, SHALL set the AXI-Stream data width.
REQ-002 Parameter LEN_W, default 16, SHALL set the width of the packet-length input and the beat counter.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 clear  input  1  SHALL be a synchronous clear of counters and sticky error.
REQ-006 ramp_start  input  DWIDTH  SHALL give the expected first word of each packet.
REQ-007 ramp_inc  input  DWIDTH  SHALL give the expected per-beat increment.
REQ-008 exp_len  input  LEN_W  SHALL give the expected beats per packet; 0 disables length checking.
REQ-009 s_axis_tdata/tvalid/tlast  input  DWIDTH/1/1  SHALL be the AXI-Stream slave data, valid and last.
REQ-010 s_axis_tready  output  1  SHALL be the AXI-Stream slave ready.
REQ-011 pkt_count  output  32  SHALL count completed packets, good or bad.
REQ-012 err_count  output  32  SHALL count errored packets.
REQ-013 err_code  output  2  SHALL hold the last error: 0 none, 1 data, 2 short, 3 long.
REQ-014 error  output  1  SHALL be sticky-high after any errored packet.
REQ-015 pkt_done, pkt_ok  output  1 each  SHALL be the completion pulse and its result.

Function
REQ-016 A beat SHALL transfer only on a cycle where tvalid and tready are both high; data is ignored otherwise.
REQ-017 FSM states SHALL be IDLE, IN_PKT and DRAIN.
REQ-018 In IDLE, a first beat SHALL latch ramp_start, ramp_inc and exp_len for the whole packet; mid-packet input changes SHALL be ignored.
REQ-019 Beat k (from 0) SHALL be expected to equal ramp_start + k*ramp_inc mod 2^DWIDTH, computed by a registered accumulator (no multiplier).
REQ-020 Data mismatch SHALL give code 1.
REQ-021 With exp_len != 0, tlast on a beat k < exp_len-1 SHALL give code 2 (short).
REQ-022 With exp_len != 0, no tlast on beat k = exp_len-1 SHALL give code 3 (long).
REQ-023 On a beat with both a data and a length error, code 1 SHALL take priority.
REQ-024 An error beat without tlast SHALL move the FSM to DRAIN.
REQ-025 DRAIN SHALL accept beats without checking until tlast, then return to IDLE.
REQ-026 Each packet SHALL count at most one error.
REQ-027 A tlast beat, including a single-beat packet from IDLE, SHALL complete the packet and return to IDLE.
REQ-028 The cycle after completion SHALL pulse pkt_done for exactly 1 cycle.
REQ-029 With that pulse, pkt_ok SHALL be high if no error occurred in the packet.
REQ-030 With that pulse, pkt_count SHALL increment; an errored packet SHALL also increment err_count, set error and update err_code.
REQ-031 pkt_count and err_count SHALL saturate at 2^32-1.
REQ-032 clear SHALL zero both counters, error and err_code; when coincident with a completion, clear SHALL win.
REQ-033 clear SHALL NOT alter FSM state or the in-flight packet.
REQ-034 The checker SHALL sustain one beat per cycle with tready held high.

Reset
REQ-035 While reset is high, all outputs SHALL be 0, including s_axis_tready.
REQ-036 Reset SHALL put the FSM in IDLE and zero the accumulator and beat counter.
REQ-037 Reset mid-packet SHALL discard the partial packet without counting it.
REQ-038 s_axis_tready SHALL be registered and rise on the first clk edge after reset deasserts.

Configuration
REQ-039 With macro AXIS_RAMP_CHECKER_THROTTLE_EN defined, s_axis_tready SHALL be driven from a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset, advanced every cycle).
REQ-040 In that mode, tready SHALL be high when LFSR bits [1:0] != 0, giving about 75% duty.
REQ-041 Without the macro, s_axis_tready SHALL be constant 1 after reset, with no LFSR logic synthesized.

Verification
REQ-042 Ramp packet: start 0x10, inc 1, exp_len 8, 8 beats with tlast on the 8th -> one pkt_done pulse, pkt_ok=1, pkt_count=1, err_count=0.
REQ-043 Data error: beat 3 of an 8-beat ramp = 0xDEAD -> pkt_ok=0, err_code=1, err_count=1, error=1, one pulse only after the 8th-beat tlast.
REQ-044 Length errors: exp_len 4 with tlast on beat 2 -> err_code=2; exp_len 4 with a 6-beat packet -> err_code=3 and DRAIN until beat 6; err_count=2.
REQ-045 Wrap and single beat: DWIDTH 64, start 0xFFFF_FFFF_FFFF_FFFE, inc 1, 4 beats -> pkt_ok=1; 1-beat packet with exp_len 1 -> pkt_ok=1.
REQ-046 Reset mid-packet after 3 of 8 beats, then a full good packet -> pkt_count=1, err_count=0.
REQ-047 Clear coincident with an errored completion -> counters and error stay 0.
REQ-048 With THROTTLE_EN, 100 back-to-back 16-beat ramps with bubbles from the source -> pkt_count=100, err_count=0.
